conv_mult_sequencer: RTL and testbench

Control FSM that drives the 16-filter × 27-tap fixed-point multiplier array through one convolution layer pass. For each group of 16 filters it loads the weights once. It then walks every output pixel: it fetches the 27-element input window, pulses the array's start strobe, waits for the array's combined valid, and hands the result slot to the downstream adder tree under a valid/ready handshake. The block does control only; no data passes through it.

---
 rtl/conv_mult_sequencer.sv | 129 ++++++++++++
 tb/tb_conv_mult_sequencer.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_mult_sequencer.sv
// Control sequencer for one convolution layer pass over the 16x27 multiplier array.
// Loads weights per filter group, then fetches/starts/waits/emits for every output pixel.
module conv_mult_sequencer #(
   parameter int PIX_W = 16,
   parameter int GRP_W = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_start,
   input  logic [PIX_W-1:0] cfg_num_pix,
   input  logic [GRP_W-1:0] cfg_num_grp,
   input  logic             cfg_abort,
   output logic             busy,
   output logic             done,
   output logic             w_req,
   output logic [GRP_W-1:0] w_grp,
   input  logic             w_ack,
   output logic             win_req,
   output logic [PIX_W-1:0] win_pix,
   input  logic             win_ack,
   output logic             mult_start,
   input  logic             mult_valid,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [PIX_W-1:0] res_pix,
   output logic [GRP_W-1:0] res_grp
);

   typedef enum logic [2:0] {
      IDLE,
      LOAD_W,
      FETCH,
      START,
      WAIT,
      EMIT
   } state_t;

   state_t           state_reg, state_next;
   logic [PIX_W-1:0] pix_reg, pix_next;
   logic [GRP_W-1:0] grp_reg, grp_next;
   logic [PIX_W-1:0] num_pix_reg, num_pix_next;
   logic [GRP_W-1:0] num_grp_reg, num_grp_next;
   logic             done_reg, done_next;
   logic             last_pix;
   logic             last_grp;

   assign last_pix = (pix_reg == num_pix_reg - PIX_W'(1));
   assign last_grp = (grp_reg == num_grp_reg - GRP_W'(1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         pix_reg     <= '0;
         grp_reg     <= '0;
         num_pix_reg <= '0;
         num_grp_reg <= '0;
         done_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         pix_reg     <= pix_next;
         grp_reg     <= grp_next;
         num_pix_reg <= num_pix_next;
         num_grp_reg <= num_grp_next;
         done_reg    <= done_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      pix_next     = pix_reg;
      grp_next     = grp_reg;
      num_pix_next = num_pix_reg;
      num_grp_next = num_grp_reg;
      done_next    = 1'b0;

      // Abort outranks any handshake completing in the same cycle.
      if (state_reg != IDLE && cfg_abort) begin
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE: begin
               if (cfg_start) begin
                  num_pix_next = cfg_num_pix;
                  num_grp_next = cfg_num_grp;
                  pix_next     = '0;
                  grp_next     = '0;
                  if (cfg_num_pix == '0 || cfg_num_grp == '0) begin
                     done_next = 1'b1;
                  end else begin
                     state_next = LOAD_W;
                  end
               end
            end
            LOAD_W: if (w_ack) state_next = FETCH;
            FETCH:  if (win_ack) state_next = START;
            START:  state_next = WAIT;
            WAIT:   if (mult_valid) state_next = EMIT;
            EMIT: begin
               if (res_ready) begin
                  if (!last_pix) begin
                     pix_next   = pix_reg + PIX_W'(1);
                     state_next = FETCH;
                  end else if (!last_grp) begin
                     pix_next   = '0;
                     grp_next   = grp_reg + GRP_W'(1);
                     state_next = LOAD_W;
                  end else begin
                     state_next = IDLE;
                     done_next  = 1'b1;
                  end
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   assign busy       = (state_reg != IDLE);
   assign done       = done_reg;
   assign w_req      = (state_reg == LOAD_W);
   assign win_req    = (state_reg == FETCH);
   assign mult_start = (state_reg == START);
   assign res_valid  = (state_reg == EMIT);
   assign w_grp      = grp_reg;
   assign win_pix    = pix_reg;
   assign res_pix    = pix_reg;
   assign res_grp    = grp_reg;

endmodule

// File: tb/tb_conv_mult_sequencer.sv
// Self-checking bench: expected result order comes from nested pixel/group loops,
// handshake responders are directed, stalled or randomized per pass.
module tb_conv_mult_sequencer;
   localparam int PIX_W = 16;
   localparam int GRP_W = 6;

   logic             clk = 1'b0;
   logic             rst;
   logic             cfg_start;
   logic [PIX_W-1:0] cfg_num_pix;
   logic [GRP_W-1:0] cfg_num_grp;
   logic             cfg_abort;
   logic             busy, done;
   logic             w_req, w_ack;
   logic [GRP_W-1:0] w_grp;
   logic             win_req, win_ack;
   logic [PIX_W-1:0] win_pix;
   logic             mult_start, mult_valid;
   logic             res_valid, res_ready;
   logic [PIX_W-1:0] res_pix;
   logic [GRP_W-1:0] res_grp;

   int errors = 0;
   int checks = 0;

   typedef enum int {PH_W, PH_WIN, PH_START, PH_WAIT, PH_RES, PH_DONE} ph_t;
   typedef struct {
      int pix;
      int grp;
   } res_t;

   conv_mult_sequencer #(.PIX_W(PIX_W), .GRP_W(GRP_W)) dut (
      .clk(clk), .rst(rst),
      .cfg_start(cfg_start), .cfg_num_pix(cfg_num_pix), .cfg_num_grp(cfg_num_grp),
      .cfg_abort(cfg_abort), .busy(busy), .done(done),
      .w_req(w_req), .w_grp(w_grp), .w_ack(w_ack),
      .win_req(win_req), .win_pix(win_pix), .win_ack(win_ack),
      .mult_start(mult_start), .mult_valid(mult_valid),
      .res_valid(res_valid), .res_ready(res_ready),
      .res_pix(res_pix), .res_grp(res_grp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [5:0] outs();
      return {busy, w_req, win_req, mult_start, res_valid, done};
   endfunction

   task automatic clear_inputs();
      cfg_start = 1'b0; cfg_abort = 1'b0;
      w_ack = 1'b0; win_ack = 1'b0; mult_valid = 1'b0; res_ready = 1'b0;
   endtask

   task automatic launch(input int np, input int ng);
      cfg_num_pix = PIX_W'(np);
      cfg_num_grp = GRP_W'(ng);
      cfg_start   = 1'b1;
      step();
      cfg_start   = 1'b0;
   endtask

   // mode 0: everything answers immediately; 1: random delays and glitches;
   // 2: window ack held 5 cycles, result ready held 7 cycles.
   function automatic bit answer(input int mode, input ph_t ph, input int pc);
      if (mode == 0) return 1'b1;
      if (mode == 2) begin
         if (ph == PH_WIN) return (pc >= 5);
         if (ph == PH_RES) return (pc >= 7);
         return 1'b1;
      end
      return ($urandom_range(0, 2) == 0);
   endfunction

   // kill: 0 none, 1 abort, 2 reset; applied in phase kill_ph after kill_idx results.
   task automatic run_pass(input int np, input int ng, input int mode,
                           input int kill, input ph_t kill_ph, input int kill_idx);
      res_t q[$];
      res_t cur;
      ph_t  ph, ph_prev;
      logic [5:0] ev;
      int   pc = 0;
      int   n = 0;
      bit   fin = 1'b0;
      bit   killed = 1'b0;
      bit   a;
      for (int g = 0; g < ng; g++)
         for (int p = 0; p < np; p++)
            q.push_back('{pix: p, grp: g});
      $display("pass np=%0d ng=%0d mode=%0d kill=%0d", np, ng, mode, kill);
      launch(np, ng);
      ph = PH_W;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         case (ph)
            PH_W:     ev = 6'b110000;
            PH_WIN:   ev = 6'b101000;
            PH_START: ev = 6'b100100;
            PH_WAIT:  ev = 6'b100000;
            PH_RES:   ev = 6'b100010;
            default:  ev = 6'b000001;
         endcase
         chk($sformatf("outs_%s", ph.name()), 32'(outs()), 32'(ev));
         if (ph == PH_W)   chk("w_grp", 32'(w_grp), q[0].grp);
         if (ph == PH_WIN) chk("win_pix", 32'(win_pix), q[0].pix);
         if (ph == PH_RES) begin
            chk("res_pix", 32'(res_pix), q[0].pix);
            chk("res_grp", 32'(res_grp), q[0].grp);
         end
         if (ph == PH_DONE) begin
            fin = 1'b1;
            break;
         end
         if (kill != 0 && ph == kill_ph && n == kill_idx) begin
            w_ack = 1'b1; win_ack = 1'b1; mult_valid = 1'b1; res_ready = 1'b1;
            if (kill == 1) cfg_abort = 1'b1; else rst = 1'b1;
            step();
            clear_inputs();
            rst = 1'b0;
            mult_valid = 1'b1;
            chk("killed_outs", 32'(outs()), 0);
            if (kill == 2) begin
               chk("rst_w_grp", 32'(w_grp), 0);
               chk("rst_win_pix", 32'(win_pix), 0);
               chk("rst_res_pix", 32'(res_pix), 0);
               chk("rst_res_grp", 32'(res_grp), 0);
            end
            step();
            mult_valid = 1'b0;
            chk("late_valid_ignored", 32'(outs()), 0);
            killed = 1'b1;
            break;
         end
         a = answer(mode, ph, pc);
         if (mode == 0) begin
            w_ack = 1'b1; win_ack = 1'b1; res_ready = 1'b1;
         end else begin
            w_ack     = (ph == PH_W)   ? a : 1'b0;
            win_ack   = (ph == PH_WIN) ? a : 1'b0;
            res_ready = (ph == PH_RES) ? a : 1'b0;
         end
         if (ph == PH_WAIT) mult_valid = a;
         else mult_valid = (mode == 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
         if (mode == 1) begin
            cfg_start   = ($urandom_range(0, 4) == 0);
            cfg_num_pix = PIX_W'($urandom_range(0, 9));
            cfg_num_grp = GRP_W'($urandom_range(0, 9));
         end
         ph_prev = ph;
         case (ph)
            PH_W:     if (w_ack) ph = PH_WIN;
            PH_WIN:   if (win_ack) ph = PH_START;
            PH_START: ph = PH_WAIT;
            PH_WAIT:  if (mult_valid) ph = PH_RES;
            PH_RES: begin
               if (res_ready) begin
                  cur = q.pop_front();
                  n++;
                  $display("  result pix=%0d grp=%0d", cur.pix, cur.grp);
                  if (q.size() == 0) ph = PH_DONE;
                  else if (q[0].grp != cur.grp) ph = PH_W;
                  else ph = PH_WIN;
               end
            end
            default: ;
         endcase
         pc = (ph == ph_prev) ? pc + 1 : 0;
         step();
      end
      clear_inputs();
      if (!killed) begin
         chk("pass_complete", 32'(fin), 1);
         chk("results_emitted", n, np * ng);
         step();
         chk("idle_after_done", 32'(outs()), 0);
      end
   endtask

   task automatic zero_launch(input int np, input int ng);
      $display("zero launch np=%0d ng=%0d", np, ng);
      launch(np, ng);
      chk("zero_done", 32'(outs()), 32'(6'b000001));
      step();
      chk("zero_idle", 32'(outs()), 0);
   endtask

   initial begin
      rst = 1'b1;
      cfg_num_pix = '0;
      cfg_num_grp = '0;
      clear_inputs();
      repeat (3) step();
      chk("reset_outs", 32'(outs()), 0);
      chk("reset_w_grp", 32'(w_grp), 0);
      chk("reset_win_pix", 32'(win_pix), 0);
      chk("reset_res_pix", 32'(res_pix), 0);
      chk("reset_res_grp", 32'(res_grp), 0);
      rst = 1'b0;
      step();

      run_pass(3, 2, 0, 0, PH_W, 0);
      run_pass(4, 2, 2, 0, PH_W, 0);
      zero_launch(0, 5);
      zero_launch(7, 0);
      run_pass(3, 2, 0, 1, PH_WAIT, 1);
      run_pass(2, 2, 0, 0, PH_W, 0);
      run_pass(3, 2, 1, 1, PH_WIN, 2);
      run_pass(3, 2, 0, 2, PH_RES, 4);
      run_pass(1, 3, 1, 0, PH_W, 0);
      for (int i = 0; i < 4; i++)
         run_pass($urandom_range(1, 6), $urandom_range(1, 4), 1, 0, PH_W, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
